// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default widths.
package dmem_arb_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data RAM port arbiter: the pipeline owns the RAM port by default; a debug
// dump stalls the pipeline and streams RAM words out over valid/ready.
// Optional macro DMEM_ARB_RANGE_EN adds i_dbg_base/i_dbg_count so a dump can
// cover a wrapping sub-range instead of the whole address space.
//
// state | meaning
// IDLE  | pipeline drives the RAM port
// DRAIN | pipeline frozen, dump pointer initialised
// FETCH | RAM read at the pointer, word captured into the output register
// SEND  | word held on o_dbg_* until the consumer accepts it
// DONE  | one-cycle completion pulse, stall still asserted
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_pipe_we,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  output logic [NB_DATA-1:0] o_pipe_rdata,
  output logic               o_stall,
  input  logic               i_dbg_start,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic               o_dbg_valid,
  input  logic               i_dbg_ready,
  output logic               o_dbg_done,
`ifdef DMEM_ARB_RANGE_EN
  input  logic [NB_ADDR-1:0] i_dbg_base,
  input  logic [NB_ADDR:0]   i_dbg_count,
`endif
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  localparam logic [NB_ADDR-1:0] PTR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] ptr_q;
  logic               at_last;
  logic               empty;
  logic               handshake;

  assign handshake = (state_q == SEND) && i_dbg_ready;

`ifdef DMEM_ARB_RANGE_EN
  localparam logic [NB_ADDR:0] REM_ONE = {{NB_ADDR{1'b0}}, 1'b1};

  logic [NB_ADDR-1:0] base_q;
  logic [NB_ADDR:0]   count_q;
  logic [NB_ADDR:0]   rem_q;

  assign at_last = (rem_q == REM_ONE);
  assign empty   = (count_q == '0);

  // Capture the requested range with the start pulse; later changes are ignored.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q  <= '0;
      count_q <= '0;
    end else if ((state_q == IDLE) && i_dbg_start) begin
      base_q  <= i_dbg_base;
      count_q <= i_dbg_count;
    end
  end

  // Words remaining in the current dump, including the one being sent.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q <= '0;
    end else if (state_q == DRAIN) begin
      rem_q <= count_q;
    end else if (handshake && !at_last) begin
      rem_q <= rem_q - REM_ONE;
    end
  end
`else
  assign at_last = (ptr_q == {NB_ADDR{1'b1}});
  assign empty   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_dbg_start) state_d = DRAIN;
      DRAIN:   state_d = empty ? DONE : FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (i_dbg_ready) state_d = at_last ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dump address pointer; wraps naturally in range mode, stops at last otherwise.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (state_q == DRAIN) begin
`ifdef DMEM_ARB_RANGE_EN
      ptr_q <= base_q;
`else
      ptr_q <= '0;
`endif
    end else if (handshake && !at_last) begin
      ptr_q <= ptr_q + PTR_ONE;
    end
  end

  // Registered debug word: loaded in FETCH, held through SEND until accepted.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dbg_data  <= '0;
      o_dbg_addr  <= '0;
      o_dbg_valid <= 1'b0;
    end else if (state_q == FETCH) begin
      o_dbg_data  <= i_mem_rdata;
      o_dbg_addr  <= ptr_q;
      o_dbg_valid <= 1'b1;
    end else if (handshake) begin
      o_dbg_valid <= 1'b0;
    end
  end

  // RAM port mux: pipeline in IDLE, dump pointer (read-only) otherwise.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = ptr_q;
    o_mem_wdata = '0;
    if (state_q == IDLE) begin
      o_mem_we    = i_pipe_we;
      o_mem_addr  = i_pipe_addr;
      o_mem_wdata = i_pipe_wdata;
    end
  end

  assign o_stall      = (state_q != IDLE);
  assign o_dbg_done   = (state_q == DONE);
  assign o_pipe_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word data RAM.
module tb_dmem_arbiter;

  logic        clk;
  logic        i_rst_n;
  logic        i_pipe_we;
  logic [7:0]  i_pipe_addr;
  logic [31:0] i_pipe_wdata;
  logic [31:0] o_pipe_rdata;
  logic        o_stall;
  logic        i_dbg_start;
  logic [31:0] o_dbg_data;
  logic [7:0]  o_dbg_addr;
  logic        o_dbg_valid;
  logic        i_dbg_ready;
  logic        o_dbg_done;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
`ifdef DMEM_ARB_RANGE_EN
  logic [7:0]  i_dbg_base;
  logic [8:0]  i_dbg_count;
`endif

  int vec_cnt;
  int err_cnt;

  logic [31:0] ram [0:255];
  logic        preload_req;

  dmem_arbiter #(.NB_DATA(32), .NB_ADDR(8)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_pipe_we    (i_pipe_we),
    .i_pipe_addr  (i_pipe_addr),
    .i_pipe_wdata (i_pipe_wdata),
    .o_pipe_rdata (o_pipe_rdata),
    .o_stall      (o_stall),
    .i_dbg_start  (i_dbg_start),
    .o_dbg_data   (o_dbg_data),
    .o_dbg_addr   (o_dbg_addr),
    .o_dbg_valid  (o_dbg_valid),
    .i_dbg_ready  (i_dbg_ready),
    .o_dbg_done   (o_dbg_done),
`ifdef DMEM_ARB_RANGE_EN
    .i_dbg_base   (i_dbg_base),
    .i_dbg_count  (i_dbg_count),
`endif
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, asynchronous read, word[a]=a on preload.
  always @(posedge clk) begin
    if (preload_req) begin
      for (int a = 0; a < 256; a++) ram[a] <= a;
    end else if (o_mem_we) begin
      ram[o_mem_addr] <= o_mem_wdata;
    end
  end
  assign i_mem_rdata = ram[o_mem_addr];

  task automatic preload();
    @(posedge clk); #1 preload_req = 1'b1;
    @(posedge clk); #1 preload_req = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({o_dbg_valid, o_dbg_done, o_stall, o_dbg_addr, o_dbg_data} !== 43'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got valid=%b done=%b stall=%b addr=%h data=%h required all 0",
               o_dbg_valid, o_dbg_done, o_stall, o_dbg_addr, o_dbg_data);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (o_stall !== 1'b0 || o_dbg_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: got stall=%b valid=%b required 0 0", o_stall, o_dbg_valid);
    end
  endtask

  task automatic test_full_dump();
    int beats, dones, done_n, stall_bad;
    preload();
    i_dbg_ready = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b1;
    beats = 0; dones = 0; done_n = 0; stall_bad = 0;
    for (int n = 1; n <= 520; n++) begin
      @(posedge clk); #1 i_dbg_start = 1'b0;
      @(negedge clk);
      if (o_dbg_valid) begin
        vec_cnt++;
        if (o_dbg_addr !== beats[7:0] || o_dbg_data !== beats || n != 3 + 2 * beats) begin
          err_cnt++;
          $display("FAIL full_beat: cycle %0d got addr=%h data=%h required addr=%h data=%h cycle %0d",
                   n, o_dbg_addr, o_dbg_data, beats[7:0], beats, 3 + 2 * beats);
        end
        beats++;
      end
      if (o_dbg_done === 1'b1) begin dones++; done_n = n; end
      if (n <= 514 && o_stall !== 1'b1) stall_bad++;
      if (n == 520) begin
        vec_cnt++;
        if (o_stall !== 1'b0) begin
          err_cnt++;
          $display("FAIL full_stall_drop: got stall=%b required 0", o_stall);
        end
      end
    end
    vec_cnt++;
    if (beats != 256) begin err_cnt++; $display("FAIL full_beat_count: got %0d required 256", beats); end
    vec_cnt++;
    if (dones != 1 || done_n != 514) begin
      err_cnt++;
      $display("FAIL full_done: got %0d pulses at cycle %0d required 1 at cycle 514", dones, done_n);
    end
    vec_cnt++;
    if (stall_bad != 0) begin err_cnt++; $display("FAIL full_stall_high: got %0d low cycles required 0", stall_bad); end
  endtask

  task automatic test_backpressure();
    int  seen, dones;
    logic [7:0]  a0;
    logic [31:0] d0;
    preload();
    i_dbg_ready = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && seen == 0; n++) begin
      @(negedge clk);
      if (o_dbg_valid && o_dbg_addr == 8'd3) seen = 1;
      else begin @(posedge clk); #1; end
    end
    vec_cnt++;
    if (seen == 0) begin err_cnt++; $display("FAIL bp_reach_addr3: got timeout required beat at addr 03"); end
    i_dbg_ready = 1'b0;
    a0 = o_dbg_addr; d0 = o_dbg_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      vec_cnt++;
      if (o_dbg_valid !== 1'b1 || o_dbg_addr !== 8'd3 || o_dbg_data !== 32'd3 || o_dbg_addr !== a0 || o_dbg_data !== d0) begin
        err_cnt++;
        $display("FAIL bp_hold: got valid=%b addr=%h data=%h required 1 03 00000003",
                 o_dbg_valid, o_dbg_addr, o_dbg_data);
      end
    end
    i_dbg_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    vec_cnt++;
    if (o_dbg_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_accept: got valid=%b required 0", o_dbg_valid); end
    @(posedge clk); @(negedge clk);
    vec_cnt++;
    if (o_dbg_valid !== 1'b1 || o_dbg_addr !== 8'd4 || o_dbg_data !== 32'd4) begin
      err_cnt++;
      $display("FAIL bp_next_beat: got valid=%b addr=%h data=%h required 1 04 00000004",
               o_dbg_valid, o_dbg_addr, o_dbg_data);
    end
    dones = 0;
    for (int n = 0; n < 600 && dones == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (o_dbg_done === 1'b1) dones = 1;
    end
    vec_cnt++;
    if (dones == 0) begin err_cnt++; $display("FAIL bp_done: got no done pulse required 1"); end
  endtask

  task automatic test_collision();
    int bad, dones;
    logic [31:0] exp;
    preload();
    i_dbg_ready = 1'b1;
    @(posedge clk); #1
    i_dbg_start = 1'b1; i_pipe_we = 1'b1; i_pipe_addr = 8'h05; i_pipe_wdata = 32'h1234;
    @(negedge clk);
    vec_cnt++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 8'h05 || o_mem_wdata !== 32'h1234 || o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL coll_commit: got we=%b addr=%h wdata=%h stall=%b required 1 05 00001234 0",
               o_mem_we, o_mem_addr, o_mem_wdata, o_stall);
    end
    @(posedge clk); #1
    i_dbg_start = 1'b0; i_pipe_addr = 8'h06; i_pipe_wdata = 32'hBAD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_mem_we !== 1'b0 || o_stall !== 1'b1) begin
        err_cnt++;
        $display("FAIL coll_blocked: cycle %0d got we=%b stall=%b required 0 1", k, o_mem_we, o_stall);
      end
      @(posedge clk); #1;
    end
    i_pipe_we = 1'b0;
    bad = 0; dones = 0;
    for (int n = 0; n < 600 && dones == 0; n++) begin
      @(negedge clk);
      if (o_dbg_valid && o_dbg_addr <= 8'h06) begin
        exp = (o_dbg_addr == 8'h05) ? 32'h1234 : {24'd0, o_dbg_addr};
        vec_cnt++;
        if (o_dbg_data !== exp) begin
          err_cnt++;
          $display("FAIL coll_dump: addr=%h got %h required %h", o_dbg_addr, o_dbg_data, exp);
        end
      end
      if (o_dbg_done === 1'b1) dones = 1;
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (dones == 0) begin err_cnt++; $display("FAIL coll_done: got no done pulse required 1"); end
  endtask

  task automatic test_reset_mid_dump();
    int seen, bad;
    preload();
    i_dbg_ready = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b0;
    seen = 0;
    for (int n = 0; n < 300 && seen == 0; n++) begin
      @(negedge clk);
      if (o_dbg_valid && o_dbg_addr == 8'h40) seen = 1;
      else begin @(posedge clk); #1; end
    end
    vec_cnt++;
    if (seen == 0) begin err_cnt++; $display("FAIL rst_reach_40: got timeout required beat at addr 40"); end
    #2 i_rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({o_dbg_valid, o_dbg_done, o_stall, o_dbg_addr, o_dbg_data} !== 43'd0) begin
      err_cnt++;
      $display("FAIL rst_async: got valid=%b done=%b stall=%b addr=%h data=%h required all 0",
               o_dbg_valid, o_dbg_done, o_stall, o_dbg_addr, o_dbg_data);
    end
    @(negedge clk) i_rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_dbg_done !== 1'b0 || o_dbg_valid !== 1'b0 || o_stall !== 1'b0) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL rst_no_done: got %0d active cycles required 0", bad); end
    @(posedge clk); #1 i_dbg_start = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && seen == 0; n++) begin
      @(negedge clk);
      if (o_dbg_valid) begin
        seen = 1;
        vec_cnt++;
        if (o_dbg_addr !== 8'h00 || o_dbg_data !== 32'd0) begin
          err_cnt++;
          $display("FAIL rst_restart: got addr=%h data=%h required 00 00000000", o_dbg_addr, o_dbg_data);
        end
      end
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (seen == 0) begin err_cnt++; $display("FAIL rst_restart_beat: got no beat required one"); end
    seen = 0;
    for (int n = 0; n < 600 && seen == 0; n++) begin
      @(negedge clk);
      if (o_dbg_done === 1'b1) seen = 1;
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (seen == 0) begin err_cnt++; $display("FAIL rst_restart_done: got no done pulse required 1"); end
  endtask

  task automatic test_pipe_only();
    preload();
    @(posedge clk); #1
    i_pipe_we = 1'b1; i_pipe_addr = 8'h10; i_pipe_wdata = 32'hDEADBEEF;
    @(negedge clk);
    vec_cnt++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 8'h10 || o_mem_wdata !== 32'hDEADBEEF || o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL pipe_write: got we=%b addr=%h wdata=%h stall=%b required 1 10 deadbeef 0",
               o_mem_we, o_mem_addr, o_mem_wdata, o_stall);
    end
    @(posedge clk); #1 i_pipe_we = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (o_pipe_rdata !== 32'hDEADBEEF || o_mem_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL pipe_read_10: got rdata=%h we=%b required deadbeef 0", o_pipe_rdata, o_mem_we);
    end
    @(posedge clk); #1 i_pipe_addr = 8'h11;
    @(negedge clk);
    vec_cnt++;
    if (o_pipe_rdata !== 32'h11) begin
      err_cnt++;
      $display("FAIL pipe_read_11: got %h required 00000011", o_pipe_rdata);
    end
  endtask

`ifdef DMEM_ARB_RANGE_EN
  task automatic test_range();
    logic [7:0] exp_a [4];
    int beats, dones, valids;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    preload();
    i_dbg_ready = 1'b1;
    @(posedge clk); #1 i_dbg_start = 1'b1; i_dbg_base = 8'hFE; i_dbg_count = 9'd4;
    @(posedge clk); #1 i_dbg_start = 1'b0; i_dbg_base = 8'h00; i_dbg_count = 9'd0;
    beats = 0; dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_dbg_valid) begin
        vec_cnt++;
        if (beats > 3 || o_dbg_addr !== exp_a[beats & 3] || o_dbg_data !== {24'd0, exp_a[beats & 3]}) begin
          err_cnt++;
          $display("FAIL range_beat: beat %0d got addr=%h data=%h required addr=%h",
                   beats, o_dbg_addr, o_dbg_data, exp_a[beats & 3]);
        end
        beats++;
      end
      if (o_dbg_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (beats != 4 || dones != 1) begin
      err_cnt++;
      $display("FAIL range_count: got %0d beats %0d dones required 4 1", beats, dones);
    end
    @(posedge clk); #1 i_dbg_start = 1'b1; i_dbg_count = 9'd0;
    @(posedge clk); #1 i_dbg_start = 1'b0;
    valids = 0; dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_dbg_valid === 1'b1) valids++;
      if (o_dbg_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (valids != 0 || dones != 1) begin
      err_cnt++;
      $display("FAIL range_zero: got %0d beats %0d dones required 0 1", valids, dones);
    end
  endtask
`endif

  initial begin
    vec_cnt = 0; err_cnt = 0;
    preload_req = 1'b0;
    i_rst_n = 1'b0; i_pipe_we = 1'b0; i_pipe_addr = '0; i_pipe_wdata = '0;
    i_dbg_start = 1'b0; i_dbg_ready = 1'b1;
`ifdef DMEM_ARB_RANGE_EN
    i_dbg_base = '0; i_dbg_count = '0;
`endif
    test_reset();
    test_full_dump();
    test_backpressure();
    test_collision();
    test_reset_mid_dump();
    test_pipe_only();
`ifdef DMEM_ARB_RANGE_EN
    test_range();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
